// File: rtl/uart_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : uart_pkg                                                       |
// | Brief   : Baud-select codes, divisor table and sequencer state encoding. |
// | Rev     : 1.0                                                            |
// +--------------------------------------------------------------------------+
package uart_pkg;

    localparam int          CNT_W       = 13;
    localparam logic [2:0]  C_SEL_9600   = 3'd0;
    localparam logic [2:0]  C_SEL_19200  = 3'd1;
    localparam logic [2:0]  C_SEL_38400  = 3'd2;
    localparam logic [2:0]  C_SEL_57600  = 3'd3;
    localparam logic [2:0]  C_SEL_115200 = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HALF = 2'd1,
        ST_BIT  = 2'd2
    } state_t;

    function automatic int unsigned baud_of(input logic [2:0] sel);
        case (sel)
            C_SEL_9600:  return 32'd9600;
            C_SEL_19200: return 32'd19200;
            C_SEL_38400: return 32'd38400;
            C_SEL_57600: return 32'd57600;
            default:     return 32'd115200;
        endcase
    endfunction

    // Rounded clock-cycles-per-bit; only ever evaluated on constants.
    function automatic logic [CNT_W-1:0] div_of(input int unsigned clk_hz, input logic [2:0] sel);
        int unsigned b;
        b = baud_of(sel);
        return CNT_W'((clk_hz + b / 2) / b);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : uart_rx_ctrl_if                                                |
// | Brief   : Valid/ready delivery channel from the receive controller.      |
// | Rev     : 1.0                                                            |
// +--------------------------------------------------------------------------+
interface uart_rx_ctrl_if;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;

    modport master (output out_data, output out_valid, input out_ready);
    modport slave  (input out_data, input out_valid, output out_ready);
endinterface
`default_nettype wire

// File: rtl/uart_baud_tick.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : uart_baud_tick                                                 |
// | Brief   : Clearable up-counter giving half-period and full-period ticks. |
// | Rev     : 1.0                                                            |
// +--------------------------------------------------------------------------+
module uart_baud_tick #(
    parameter int W = 13
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         full_i,
    input  logic [W-1:0] div_i,
    output logic         half_tick_o,
    output logic         full_tick_o
);
    localparam logic [W-1:0] C_ONE = W'(1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;
    logic [W-1:0] half_w;

    assign half_w      = div_i >> 1;
    assign half_tick_o = ~full_i & (cnt_q == half_w - C_ONE);
    assign full_tick_o =  full_i & (cnt_q == div_i  - C_ONE);

    // Either tick restarts the count so the next period begins at zero.
    always_comb begin
        cnt_d = cnt_q + C_ONE;
        if (clr_i || half_tick_o || full_tick_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule
`default_nettype wire

// File: rtl/uart_rx_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : uart_rx_ctrl                                                   |
// | Brief   : UART receive baud sequencer, frame check and byte delivery.    |
// | Rev     : 1.0                                                            |
// +--------------------------------------------------------------------------+
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ  = 50_000_000,
    parameter logic [2:0]  DEF_SEL = 3'd4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rs232_rx,
    input  logic                  bps_start,
    input  logic                  rx_int,
    input  logic [7:0]            rx_data,
    input  logic [2:0]            baud_sel,
    output logic                  clk_bps,
    uart_rx_ctrl_if.master        dn,
    output logic                  frame_err,
    output logic                  overrun,
    input  logic                  overrun_clr
);
    localparam logic [CNT_W-1:0] C_DIV_9600   = div_of(CLK_HZ, C_SEL_9600);
    localparam logic [CNT_W-1:0] C_DIV_19200  = div_of(CLK_HZ, C_SEL_19200);
    localparam logic [CNT_W-1:0] C_DIV_38400  = div_of(CLK_HZ, C_SEL_38400);
    localparam logic [CNT_W-1:0] C_DIV_57600  = div_of(CLK_HZ, C_SEL_57600);
    localparam logic [CNT_W-1:0] C_DIV_115200 = div_of(CLK_HZ, C_SEL_115200);
    localparam logic [CNT_W-1:0] C_DIV_DEF    = div_of(CLK_HZ, DEF_SEL);

    state_t           state_q, state_d;
    logic             rx_meta_q, rx_sync_q;
    logic             bps_q, bps_prev_q;
    logic             rx_int_q;
    logic [CNT_W-1:0] div_q, div_sel_w;
    logic [3:0]       pidx_q;
    logic             bad_q;
    logic             clk_bps_q, frame_err_q, overrun_q, out_valid_q;
    logic [7:0]       out_data_q;

    logic strobe_w, tick_clr_w, tick_full_w, half_tick_w, full_tick_w;
    logic bps_rise_w, start_w, eof_w, good_eof_w, consume_w;

    always_comb begin
        case (baud_sel)
            C_SEL_9600:   div_sel_w = C_DIV_9600;
            C_SEL_19200:  div_sel_w = C_DIV_19200;
            C_SEL_38400:  div_sel_w = C_DIV_38400;
            C_SEL_57600:  div_sel_w = C_DIV_57600;
            C_SEL_115200: div_sel_w = C_DIV_115200;
            default:      div_sel_w = C_DIV_DEF;
        endcase
    end

    assign bps_rise_w  = bps_q & ~bps_prev_q;
    assign start_w     = (state_q == ST_IDLE) & bps_rise_w;
    assign tick_full_w = (state_q == ST_BIT);

    uart_baud_tick #(.W(CNT_W)) u_tick (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr_i       (tick_clr_w),
        .full_i      (tick_full_w),
        .div_i       (div_q),
        .half_tick_o (half_tick_w),
        .full_tick_o (full_tick_w)
    );

    always_comb begin
        state_d    = state_q;
        strobe_w   = 1'b0;
        tick_clr_w = 1'b0;
        case (state_q)
            ST_IDLE: begin
                tick_clr_w = 1'b1;
                if (bps_rise_w) state_d = ST_HALF;
            end
            ST_HALF: begin
                if (half_tick_w) begin
                    strobe_w = 1'b1;
                    state_d  = ST_BIT;
                end
            end
            ST_BIT: begin
                if (full_tick_w) strobe_w = 1'b1;
            end
            default: begin
                state_d    = ST_IDLE;
                tick_clr_w = 1'b1;
            end
        endcase
        if (!bps_q) begin
            state_d    = ST_IDLE;
            strobe_w   = 1'b0;
            tick_clr_w = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // bps_start history resets high so a request held across reset is not a new edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            bps_q      <= 1'b1;
            bps_prev_q <= 1'b1;
            rx_int_q   <= 1'b0;
            div_q      <= C_DIV_DEF;
            pidx_q     <= 4'd0;
            bad_q      <= 1'b0;
            clk_bps_q  <= 1'b0;
        end else begin
            rx_meta_q  <= rs232_rx;
            rx_sync_q  <= rx_meta_q;
            bps_q      <= bps_start;
            bps_prev_q <= bps_q;
            rx_int_q   <= rx_int;
            clk_bps_q  <= strobe_w;
            if (start_w) begin
                div_q  <= div_sel_w;
                pidx_q <= 4'd0;
                bad_q  <= 1'b0;
            end else if (strobe_w) begin
                if ((pidx_q == 4'd0 && rx_sync_q) || (pidx_q == 4'd9 && !rx_sync_q)) begin
                    bad_q <= 1'b1;
                end
                if (pidx_q != 4'd10) pidx_q <= pidx_q + 4'd1;
            end
        end
    end

    assign eof_w      = rx_int_q & ~rx_int;
    assign good_eof_w = eof_w & ~bad_q;
    assign consume_w  = out_valid_q & dn.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q  <= 8'd0;
            out_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            frame_err_q <= eof_w & bad_q;
            if (good_eof_w && (!out_valid_q || dn.out_ready)) begin
                out_data_q  <= rx_data;
                out_valid_q <= 1'b1;
            end else if (consume_w) begin
                out_valid_q <= 1'b0;
            end
            if (good_eof_w && out_valid_q && !dn.out_ready) begin
                overrun_q <= 1'b1;
            end else if (overrun_clr) begin
                overrun_q <= 1'b0;
            end
        end
    end

    assign clk_bps      = clk_bps_q;
    assign frame_err    = frame_err_q;
    assign overrun      = overrun_q;
    assign dn.out_data  = out_data_q;
    assign dn.out_valid = out_valid_q;
endmodule
`default_nettype wire

// File: tb/tb_uart_rx_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_uart_rx_ctrl                                                |
// | Brief   : Acts as uart_rx around the controller against a frame model.   |
// | Rev     : 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_uart_rx_ctrl;
    localparam int C_CLK_HZ = 50_000_000;

    logic       clk = 1'b0;
    logic       rst_n, rs232_rx, bps_start, rx_int, overrun_clr, out_ready;
    logic [7:0] rx_data;
    logic [2:0] baud_sel;
    logic       clk_bps, frame_err, overrun;

    uart_rx_ctrl_if dn();
    assign dn.out_ready = out_ready;

    uart_rx_ctrl #(.CLK_HZ(C_CLK_HZ), .DEF_SEL(3'd4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rs232_rx    (rs232_rx),
        .bps_start   (bps_start),
        .rx_int      (rx_int),
        .rx_data     (rx_data),
        .baud_sel    (baud_sel),
        .clk_bps     (clk_bps),
        .dn          (dn),
        .frame_err   (frame_err),
        .overrun     (overrun),
        .overrun_clr (overrun_clr)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    int t0    = 0;
    int ferr_cnt = 0;
    int pulses[$];
    bit rand_ready = 1'b0;
    bit exp_bad    = 1'b0;

    // Reference delivery state
    bit       m_valid, m_ferr, m_ovr, m_rxint_prev;
    bit [7:0] m_data;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
            if (n_err >= 100) begin
                $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
                $finish;
            end
        end
    endtask

    function automatic int mdl_div(input logic [2:0] sel);
        int b;
        case (sel)
            3'd0:    b = 9600;
            3'd1:    b = 19200;
            3'd2:    b = 38400;
            3'd3:    b = 57600;
            default: b = 115200;
        endcase
        return (C_CLK_HZ + b / 2) / b;
    endfunction

    task automatic step();
        bit eof;
        @(posedge clk);
        cyc++;
        if (!rst_n) begin
            m_valid = 0; m_ferr = 0; m_ovr = 0; m_rxint_prev = 0; m_data = 8'd0;
        end else begin
            eof    = m_rxint_prev && !rx_int;
            m_ferr = eof && exp_bad;
            if (eof && !exp_bad) begin
                if (!m_valid || out_ready) begin
                    m_data  = rx_data;
                    m_valid = 1;
                end else begin
                    m_ovr = 1;
                end
            end else begin
                if (m_valid && out_ready) m_valid = 0;
                if (overrun_clr) m_ovr = 0;
            end
            if (eof && !exp_bad && m_valid && overrun_clr && !m_ovr) m_ovr = 0;
            m_rxint_prev = rx_int;
        end
        @(negedge clk);
        if (clk_bps) pulses.push_back(cyc - t0);
        if (frame_err) ferr_cnt++;
        check_eq("out_valid", int'(dn.out_valid), int'(m_valid));
        check_eq("out_data",  int'(dn.out_data),  int'(m_data));
        check_eq("frame_err", int'(frame_err),    int'(m_ferr));
        check_eq("overrun",   int'(overrun),      int'(m_ovr));
        if (rand_ready) out_ready = ($urandom_range(0, 3) == 0);
    endtask

    task automatic check_pulse_times(input string tag, input int half, input int div);
        for (int i = 0; i < pulses.size(); i++) begin
            check_eq($sformatf("%s_pulse%0d_t", tag, i), pulses[i], half + 1 + i * div);
        end
    endtask

    // Drives one frame as uart_rx would; bit b of the line spans edges [b*div,(b+1)*div).
    task automatic run_frame(input string tag, input logic [7:0] d, input logic [2:0] sel,
                             input logic [2:0] sel_mid, input bit stop_bit, input bit glitch,
                             input int npulses, input int rst_at);
        int div, half, e, bi, limit, ferr0;
        bit done;
        div     = mdl_div(sel);
        half    = div / 2;
        exp_bad = glitch || (npulses >= 10 && !stop_bit);
        pulses.delete();
        baud_sel  = sel;
        rx_data   = 8'($urandom);
        bps_start = 1'b1;
        rx_int    = 1'b1;
        t0        = cyc + 1;
        limit     = half + 2 + npulses * div + 20;
        done      = 1'b0;
        for (int k = 0; k < limit && !done; k++) begin
            e  = cyc + 1 - t0;
            bi = e / div;
            if (glitch)        rs232_rx = (e >= 100);
            else if (bi == 0)  rs232_rx = 1'b0;
            else if (bi <= 8)  rs232_rx = d[bi-1];
            else if (bi == 9)  rs232_rx = stop_bit;
            else               rs232_rx = 1'b1;
            if (pulses.size() >= 1) baud_sel = sel_mid;
            step();
            if (rst_at > 0 && pulses.size() == rst_at) done = 1'b1;
            if (pulses.size() == npulses) done = 1'b1;
        end
        check_eq({tag, "_timeout"}, int'(done), 1);
        if (rst_at > 0) begin
            rst_n    = 1'b0;
            rx_int   = 1'b0;
            rs232_rx = 1'b1;
            repeat (3) step();
            check_eq({tag, "_rst_bps"},   int'(clk_bps),      0);
            check_eq({tag, "_rst_valid"}, int'(dn.out_valid), 0);
            check_eq({tag, "_rst_data"},  int'(dn.out_data),  0);
            check_eq({tag, "_rst_ovr"},   int'(overrun),      0);
            rst_n = 1'b1;
            repeat (600) step();
            check_eq({tag, "_no_pulse_after_rst"}, pulses.size(), rst_at);
            bps_start = 1'b0;
            repeat (4) step();
        end else begin
            ferr0     = ferr_cnt;
            bps_start = 1'b0;
            rx_int    = 1'b0;
            rx_data   = d;
            rs232_rx  = 1'b1;
            step();
            rx_data = 8'($urandom);
            repeat (500) step();
            check_eq({tag, "_npulses"}, pulses.size(), npulses);
            check_eq({tag, "_ferr_cnt"}, ferr_cnt - ferr0, int'(exp_bad));
        end
        check_pulse_times(tag, half, div);
    endtask

    initial begin
        logic [7:0] rd;
        rst_n = 1'b0; bps_start = 1'b0; rx_int = 1'b0; rx_data = 8'd0; baud_sel = 3'd4;
        rs232_rx = 1'b1; out_ready = 1'b0; overrun_clr = 1'b0;
        repeat (3) step();
        check_eq("rst_clk_bps",   int'(clk_bps),      0);
        check_eq("rst_out_valid", int'(dn.out_valid), 0);
        check_eq("rst_out_data",  int'(dn.out_data),  0);
        check_eq("rst_frame_err", int'(frame_err),    0);
        check_eq("rst_overrun",   int'(overrun),      0);
        rst_n = 1'b1;
        repeat (5) step();

        // Good 115200 frame held in the register
        run_frame("a5", 8'hA5, 3'd4, 3'd4, 1'b1, 1'b0, 11, 0);
        check_eq("a5_first",  pulses[0], 218);
        check_eq("a5_space",  pulses[1] - pulses[0], 434);
        check_eq("a5_data",   int'(dn.out_data), 8'hA5);
        check_eq("a5_valid",  int'(dn.out_valid), 1);
        out_ready = 1'b1;
        repeat (2) step();
        check_eq("a5_consumed", int'(dn.out_valid), 0);

        run_frame("3c_stop", 8'h3C, 3'd4, 3'd4, 1'b0, 1'b0, 11, 0);
        check_eq("3c_valid", int'(dn.out_valid), 0);

        run_frame("glitch", 8'hFF, 3'd4, 3'd4, 1'b1, 1'b1, 1, 0);
        check_eq("glitch_valid", int'(dn.out_valid), 0);

        // Overrun with a stalled consumer
        out_ready = 1'b0;
        run_frame("b11", 8'h11, 3'd4, 3'd4, 1'b1, 1'b0, 11, 0);
        run_frame("b22", 8'h22, 3'd4, 3'd4, 1'b1, 1'b0, 11, 0);
        check_eq("ovr_data", int'(dn.out_data), 8'h11);
        check_eq("ovr_set",  int'(overrun), 1);
        overrun_clr = 1'b1;
        step();
        overrun_clr = 1'b0;
        check_eq("ovr_clr", int'(overrun), 0);
        out_ready = 1'b1;
        repeat (2) step();
        check_eq("ovr_consumed", int'(dn.out_valid), 0);

        // Baud latched per frame: 9600 stays 9600 despite a mid-frame change
        run_frame("sel0", 8'h5A, 3'd0, 3'd4, 1'b1, 1'b0, 3, 0);
        check_eq("sel0_space", pulses[1] - pulses[0], 5208);
        run_frame("sel7", 8'hC3, 3'd7, 3'd0, 1'b1, 1'b0, 11, 0);
        check_eq("sel7_space", pulses[2] - pulses[1], 434);

        rd = 8'($urandom);
        run_frame("rst_mid", rd, 3'd4, 3'd4, 1'b1, 1'b0, 11, 5);
        out_ready = 1'b0;
        rd = 8'($urandom);
        run_frame("after_rst", rd, 3'd4, 3'd4, 1'b1, 1'b0, 11, 0);
        check_eq("after_rst_data",  int'(dn.out_data), int'(rd));
        check_eq("after_rst_valid", int'(dn.out_valid), 1);

        rand_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            run_frame($sformatf("rnd%0d", i), 8'($urandom), 3'($urandom_range(4, 7)), 3'($urandom),
                      ($urandom_range(0, 3) != 0), 1'b0, 11, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
